// File: rtl/tbird_pkg.sv
// Shared types and lamp patterns for the Thunderbird tail-light sequencer.
package tbird_pkg;

  typedef enum logic [3:0] {
    IDLE,
    L1,
    L2,
    L3,
    GAP_L,
    R1,
    R2,
    R3,
    GAP_R,
    HAZ,
    GAP_H
  } state_t;

  // Side vectors are {c, b, a}: outer lamp in bit 2, inner lamp in bit 0.
  localparam logic [2:0] PAT_1   = 3'b001;
  localparam logic [2:0] PAT_2   = 3'b011;
  localparam logic [2:0] PAT_3   = 3'b111;
  localparam logic [2:0] PAT_OFF = 3'b000;
  localparam logic [2:0] PAT_ON  = 3'b111;

  // Request arbitration shared by IDLE and every GAP state.
  function automatic state_t arbitrate(input logic haz_req, input logic left_req,
                                       input logic right_req);
    if (haz_req)        return HAZ;
    else if (left_req)  return L1;
    else if (right_req) return R1;
    else                return IDLE;
  endfunction

endpackage

// File: rtl/tbird_step_tick.sv
// Animation-step prescaler: pulses step_tick once every TICK_DIV running cycles.
module tbird_step_tick #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic step_tick
);

  localparam logic [7:0] LAST = 8'(TICK_DIV - 1);

  logic [7:0] count_q, count_d;

  assign step_tick = run && (count_q == LAST);

  // Next count: held at zero while cleared, wraps on the tick, else counts up.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves count_d unassigned (latch).
    count_d = count_q;
    if (clear || step_tick) begin
      count_d = '0;
    end else if (run) begin
      count_d = count_q + 8'd1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tbird_signal_ctrl.sv
// Turn/hazard/brake sequencer: arbitrates requests, steps the animation at the
// prescaled rate and overlays brake lighting on the side not being animated.
module tbird_signal_ctrl
  import tbird_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic left,
  input  logic right,
  input  logic hazard,
  input  logic brake,
  output logic lc,
  output logic lb,
  output logic la,
  output logic ra,
  output logic rb,
  output logic rc,
  output logic busy
);

  state_t     state_q, state_d;
  logic       brake_q;
  logic       step_tick;
  logic       haz_req;
  logic       in_idle;
  logic [2:0] left_v, right_v;

  assign haz_req = hazard | (left & right);
  assign in_idle = (state_q == IDLE);

  // The counter sits at zero in IDLE, so the first step after leaving IDLE is full length.
  tbird_step_tick #(.TICK_DIV(TICK_DIV)) u_step_tick (
    .clk      (clk),
    .reset    (reset),
    .clear    (in_idle),
    .run      (!in_idle),
    .step_tick(step_tick)
  );

  // State and brake registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      brake_q <= 1'b0;
    end else begin
      state_q <= state_d;
      brake_q <= brake;
    end
  end

  // Next state: IDLE arbitrates every cycle, everything else moves only on a step tick.
  always_comb begin
    state_d = state_q;
    if (in_idle) begin
      state_d = arbitrate(haz_req, left, right);
    end else if (step_tick) begin
      case (state_q)
        L1:                   state_d = haz_req ? HAZ : L2;
        L2:                   state_d = haz_req ? HAZ : L3;
        L3:                   state_d = haz_req ? HAZ : GAP_L;
        R1:                   state_d = haz_req ? HAZ : R2;
        R2:                   state_d = haz_req ? HAZ : R3;
        R3:                   state_d = haz_req ? HAZ : GAP_R;
        HAZ:                  state_d = GAP_H;
        GAP_L, GAP_R, GAP_H:  state_d = arbitrate(haz_req, left, right);
        default:              state_d = IDLE;
      endcase
    end
  end

  // Lamp decode from registered state and brake only; brake lights the side not animated.
  always_comb begin
    left_v  = PAT_OFF;
    right_v = PAT_OFF;
    case (state_q)
      L1:      left_v  = PAT_1;
      L2:      left_v  = PAT_2;
      L3:      left_v  = PAT_3;
      R1:      right_v = PAT_1;
      R2:      right_v = PAT_2;
      R3:      right_v = PAT_3;
      HAZ: begin
        left_v  = PAT_ON;
        right_v = PAT_ON;
      end
      default: ;
    endcase
    if (brake_q) begin
      case (state_q)
        L1, L2, L3, GAP_L: right_v = PAT_ON;
        R1, R2, R3, GAP_R: left_v  = PAT_ON;
        default: begin
          left_v  = PAT_ON;
          right_v = PAT_ON;
        end
      endcase
    end
  end

  assign {lc, lb, la} = left_v;
  assign {rc, rb, ra} = right_v;
  assign busy         = !in_idle;

endmodule

// File: tb/tb_tbird_signal_ctrl.sv
// Scoreboard bench for tbird_signal_ctrl: two instances (TICK_DIV 4 and 1) share
// stimulus; a step/age reference model predicts lamps, a monitor compares each cycle.
module tb_tbird_signal_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic left = 1'b0, right = 1'b0, hazard = 1'b0, brake = 1'b0;
  logic [6:0] o4, o1;  // {lc,lb,la,ra,rb,rc,busy}

  always #5 clk = ~clk;

  tbird_signal_ctrl #(.TICK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard), .brake(brake),
    .lc(o4[6]), .lb(o4[5]), .la(o4[4]), .ra(o4[3]), .rb(o4[2]), .rc(o4[1]), .busy(o4[0])
  );

  tbird_signal_ctrl #(.TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard), .brake(brake),
    .lc(o1[6]), .lb(o1[5]), .la(o1[4]), .ra(o1[3]), .rb(o1[2]), .rc(o1[1]), .busy(o1[0])
  );

  // Reference model: which sequence runs, which step of it, how long in that step.
  typedef enum int {M_IDLE, M_LEFT, M_RIGHT, M_HAZ} kind_e;
  typedef struct {
    kind_e kind;
    int    step;   // LEFT/RIGHT: 0..2 lit, 3 gap. HAZ: 0 lit, 1 gap.
    int    age;    // cycles already spent in the current step
    bit    bq;     // brake as seen one cycle late
  } mstate_t;
  typedef struct packed {
    logic [6:0] e4;
    logic [6:0] e1;
  } exp_t;

  exp_t    sb_q[$];
  mstate_t m4, m1;
  int      checks = 0;
  int      failures = 0;
  string   phase = "reset";

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got {lc,lb,la,ra,rb,rc,busy}=%b expected %b", name, $time, act, exp);
    end
  endtask

  function automatic mstate_t model_step(input mstate_t s, input int td,
                                         input bit l, input bit r, input bit h,
                                         input bit b, input bit rst);
    mstate_t n = s;
    bit haz = h | (l & r);
    bit rearb = 1'b0;
    if (rst) begin
      n.kind = M_IDLE; n.step = 0; n.age = 0; n.bq = 1'b0;
      return n;
    end
    n.bq = b;
    if (s.kind == M_IDLE) begin
      rearb = 1'b1;
    end else if (s.age < td - 1) begin
      n.age = s.age + 1;
    end else begin
      n.age = 0;
      if (s.step == ((s.kind == M_HAZ) ? 1 : 3)) rearb = 1'b1;
      else if (s.kind != M_HAZ && haz) begin
        n.kind = M_HAZ; n.step = 0;
      end else n.step = s.step + 1;
    end
    if (rearb) begin
      n.step = 0; n.age = 0;
      if (haz)    n.kind = M_HAZ;
      else if (l) n.kind = M_LEFT;
      else if (r) n.kind = M_RIGHT;
      else        n.kind = M_IDLE;
    end
    return n;
  endfunction

  function automatic logic [6:0] model_out(input mstate_t s);
    logic [2:0] lv, rv, lit, side;
    lit  = (s.step < 3) ? 3'((1 << (s.step + 1)) - 1) : 3'b000;
    side = s.bq ? 3'b111 : 3'b000;
    lv = side;
    rv = side;
    case (s.kind)
      M_LEFT:  lv = lit;
      M_RIGHT: rv = lit;
      M_HAZ:   if (s.step == 0) begin lv = 3'b111; rv = 3'b111; end
      default: ;
    endcase
    return {lv[2], lv[1], lv[0], rv[0], rv[1], rv[2], (s.kind != M_IDLE)};
  endfunction

  // Drive inputs at the falling edge; predict the state after the next rising edge.
  task automatic drive(input bit l, input bit r, input bit h, input bit b, input bit rst,
                       input int n);
    exp_t e;
    repeat (n) begin
      @(negedge clk);
      left = l; right = r; hazard = h; brake = b; reset = rst;
      m4 = model_step(m4, 4, l, r, h, b, rst);
      m1 = model_step(m1, 1, l, r, h, b, rst);
      e.e4 = model_out(m4);
      e.e1 = model_out(m1);
      sb_q.push_back(e);
    end
  endtask

  // Monitor: after each rising edge, compare both DUTs against the oldest prediction.
  exp_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check({phase, "/div4"}, o4, mon_e.e4);
        check({phase, "/div1"}, o1, mon_e.e1);
      end
    end
  end

  bit rl = 0, rr = 0, rh = 0, rb_ = 0, rrst = 0;
  int waited = 0;

  initial begin
    m4 = '{kind: M_IDLE, step: 0, age: 0, bq: 1'b0};
    m1 = m4;

    phase = "reset";        drive(0, 0, 0, 0, 1, 2);
    phase = "left_hold";    drive(1, 0, 0, 0, 0, 40);
    phase = "drain";        drive(0, 0, 0, 0, 0, 20);
    phase = "right_pulse";  drive(0, 1, 0, 0, 0, 1);  drive(0, 0, 0, 0, 0, 24);
    phase = "hazard_lr";    drive(1, 1, 0, 0, 0, 20); drive(0, 0, 0, 0, 0, 12);
    phase = "preempt";      drive(1, 0, 0, 0, 0, 1);  drive(0, 1, 0, 0, 0, 3);
                            drive(0, 0, 0, 0, 0, 2);  drive(0, 0, 1, 0, 0, 2);
                            drive(0, 0, 0, 0, 0, 12);
    phase = "right_in_l1";  drive(1, 0, 0, 0, 0, 1);  drive(0, 1, 0, 0, 0, 18);
                            drive(0, 0, 0, 0, 0, 20);
    phase = "brake_left";   drive(1, 0, 0, 1, 0, 20);
    phase = "brake_idle";   drive(0, 0, 0, 1, 0, 20); drive(0, 0, 0, 0, 0, 4);
    phase = "reset_mid";    drive(1, 0, 0, 0, 0, 10); drive(1, 0, 0, 0, 1, 1);
                            drive(1, 0, 0, 0, 0, 8);  drive(0, 0, 0, 0, 0, 20);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) rl = ~rl;
      if ($urandom_range(0, 19) == 0) rr = ~rr;
      if ($urandom_range(0, 39) == 0) rh = ~rh;
      if ($urandom_range(0, 14) == 0) rb_ = ~rb_;
      rrst = ($urandom_range(0, 299) == 0);
      drive(rl, rr, rh, rb_, rrst, 1);
    end

    while (sb_q.size() != 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
